// File: rtl/pmem_arbiter_pkg.sv
// Shared LC-3b types for the physical-memory arbiter: line type, arbiter states
// and the latched request record.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } pmem_arb_state_t;

  typedef struct packed {
    logic     write;
    lc3b_word address;
    lc3b_line wdata;
  } pmem_req_t;

endpackage

// File: rtl/pmem_arbiter_watchdog.sv
// Per-transaction watchdog: saturating wait counter and a sticky expiry flag that
// only reset clears.
module arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic active,
  input  logic done,
  output logic expired
);

  localparam int unsigned CW = (TIMEOUT_CYCLES < 1) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] ONE   = CW'(1);

  logic [CW-1:0] count;

  // Counter is held at zero outside SERVE, so every transaction starts from zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      expired <= 1'b0;
    end else if (!active) begin
      count <= '0;
    end else if (!done && (count != LIMIT)) begin
      count <= count + ONE;
      if (count == (LIMIT - ONE)) begin
        expired <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/pmem_arbiter.sv
// Arbitrates the single pmem line port between I-cache and D-cache misses; latches
// one request at grant and returns the completion pulse to its owner only.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter bit          ROUND_ROBIN    = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         icache_read,
  input  lc3b_word     icache_address,
  output lc3b_line     icache_rdata,
  output logic         icache_resp,
  input  logic         dcache_read,
  input  logic         dcache_write,
  input  lc3b_word     dcache_address,
  input  lc3b_line     dcache_wdata,
  output lc3b_line     dcache_rdata,
  output logic         dcache_resp,
  output logic         pmem_read,
  output logic         pmem_write,
  output lc3b_word     pmem_address,
  output lc3b_line     pmem_wdata,
  input  lc3b_line     pmem_rdata,
  input  logic         pmem_resp,
  output logic         arb_timeout,
  output logic [1:0]   arb_state
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SERVE_I = SERVE_I;
  localparam logic [1:0] ST_SERVE_D = SERVE_D;

  // Handshake: a cache raises read/write and holds it; the arbiter answers with a
  // one-cycle x_resp in the cycle pmem_resp arrives. pmem sees read/write held from
  // the cycle after grant until pmem_resp; pmem_resp outside SERVE is ignored.

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant_d;
  pmem_req_t  req_q;
  pmem_req_t  req_next;
  logic       i_req;
  logic       d_req;
  logic       grant_d;
  logic       grant_i;
  logic       serving;

  assign i_req   = icache_read;
  assign d_req   = dcache_read | dcache_write;
  // On a tie D wins unless round-robin says D was served last.
  assign grant_d = d_req && (!i_req || !ROUND_ROBIN || !last_grant_d);
  assign grant_i = i_req && !grant_d;
  assign serving = (state == ST_SERVE_I) || (state == ST_SERVE_D);

  always_comb begin
    state_next = state;
    req_next   = req_q;
    case (state)
      ST_IDLE: begin
        if (grant_d) begin
          state_next = ST_SERVE_D;
          req_next   = '{write: dcache_write, address: dcache_address, wdata: dcache_wdata};
        end else if (grant_i) begin
          state_next = ST_SERVE_I;
          req_next   = '{write: 1'b0, address: icache_address, wdata: '0};
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (pmem_resp) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      last_grant_d <= 1'b0;
      req_q        <= '0;
    end else begin
      state <= state_next;
      req_q <= req_next;
      if (serving && pmem_resp) begin
        last_grant_d <= (state == ST_SERVE_D);
      end
    end
  end

  assign pmem_read    = serving && !req_q.write;
  assign pmem_write   = serving && req_q.write;
  assign pmem_address = req_q.address;
  assign pmem_wdata   = req_q.wdata;
  assign icache_resp  = (state == ST_SERVE_I) && pmem_resp;
  assign dcache_resp  = (state == ST_SERVE_D) && pmem_resp;
  assign icache_rdata = pmem_rdata;
  assign dcache_rdata = pmem_rdata;
  assign arb_state    = state;

  arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .active (serving),
    .done   (pmem_resp),
    .expired(arb_timeout)
  );

endmodule
